// File: rtl/toggle_cover_collector.sv
// toggle_cover_collector: samples a monitored bus, detects rising (and,
// optionally, falling) bit transitions, records first hits in a sticky
// bitmap and drains each newly covered point as a global cover index over
// a valid/ready stream.
//
// Optional feature macro: TOGGLE_COVER_FALL_EN
//   defined   -> fall transitions are covered too, NPTS = 2*WIDTH and the
//                fall of bit i maps to local point WIDTH+i
//   undefined -> rise coverage only, NPTS = WIDTH
module toggle_cover_collector #(
  parameter int WIDTH       = 44,
  parameter int COVER_INDEX = 0,
  parameter int IDX_W       = 32,
`ifdef TOGGLE_COVER_FALL_EN
  localparam int NPTS       = 2 * WIDTH,
`else
  localparam int NPTS       = WIDTH,
`endif
  localparam int CNT_W      = $clog2(NPTS + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] sig,
  input  logic             enable,
  input  logic             clear,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_index,
  output logic [CNT_W-1:0] covered_count,
  output logic             all_covered
);

  localparam int PT_W = (NPTS > 1) ? $clog2(NPTS) : 1;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_SEND = 1'b1;

  logic [WIDTH-1:0] prev_q;
  logic             primed_q;

  logic [NPTS-1:0]  hit_q, hit_d;
  logic [NPTS-1:0]  pending_q, pending_d;
  logic [NPTS-1:0]  det;
  logic [NPTS-1:0]  new_pts;
  logic [NPTS-1:0]  take_mask;

  logic [WIDTH-1:0] rise;
`ifdef TOGGLE_COVER_FALL_EN
  logic [WIDTH-1:0] fall;
`endif

  logic [0:0]       state_q, state_d;
  logic [IDX_W-1:0] out_index_q, out_index_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             all_q, all_d;

  logic [PT_W-1:0]  low_pt;
  logic             low_found;
  logic             any_pending;
  logic             load;
  logic [CNT_W-1:0] new_cnt;

  // Transition detection, suppressed until the first post-reset sample exists
  always_comb begin
    rise = '0;
`ifdef TOGGLE_COVER_FALL_EN
    fall = '0;
`endif
    if (primed_q && enable) begin
      rise = ~prev_q & sig;
`ifdef TOGGLE_COVER_FALL_EN
      fall = prev_q & ~sig;
`endif
    end
`ifdef TOGGLE_COVER_FALL_EN
    det = {fall, rise};
`else
    det = rise;
`endif
    new_pts = det & ~hit_q;
  end

  // Lowest-numbered pending point selects the next index to emit
  always_comb begin
    low_pt    = '0;
    low_found = 1'b0;
    for (int unsigned i = 0; i < NPTS; i++) begin
      if (pending_q[i] && !low_found) begin
        low_pt    = PT_W'(i);
        low_found = 1'b1;
      end
    end
    any_pending = |pending_q;
  end

  // Number of points first hit this cycle
  always_comb begin
    new_cnt = '0;
    for (int unsigned i = 0; i < NPTS; i++) begin
      new_cnt = new_cnt + CNT_W'(new_pts[i]);
    end
  end

  // Emitter FSM and coverage next-state; clear overrides everything else
  always_comb begin
    state_d     = state_q;
    out_index_d = out_index_q;
    load        = 1'b0;
    take_mask   = '0;

    case (state_q)
      S_IDLE: begin
        if (any_pending) load = 1'b1;
      end
      S_SEND: begin
        if (out_ready) begin
          if (any_pending) load = 1'b1;
          else             state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (load) begin
      state_d     = S_SEND;
      out_index_d = IDX_W'(COVER_INDEX) + IDX_W'(low_pt);
      take_mask   = NPTS'(1) << low_pt;
    end

    // New bits are OR-ed after the take so a same-cycle set on another bit survives
    hit_d     = hit_q | new_pts;
    pending_d = (pending_q & ~take_mask) | new_pts;
    count_d   = count_q + new_cnt;

    if (clear) begin
      state_d   = S_IDLE;
      hit_d     = '0;
      pending_d = '0;
      count_d   = '0;
    end

    all_d = (count_d == CNT_W'(NPTS));
  end

  // Input history: prev follows sig every cycle regardless of enable/clear
  always_ff @(posedge clock) begin
    if (reset) begin
      prev_q   <= '0;
      primed_q <= 1'b0;
    end else begin
      prev_q   <= sig;
      primed_q <= 1'b1;
    end
  end

  // Coverage bitmap, pending set, counters and emitter registers
  always_ff @(posedge clock) begin
    if (reset) begin
      hit_q       <= '0;
      pending_q   <= '0;
      count_q     <= '0;
      all_q       <= 1'b0;
      state_q     <= S_IDLE;
      out_index_q <= '0;
    end else begin
      hit_q       <= hit_d;
      pending_q   <= pending_d;
      count_q     <= count_d;
      all_q       <= all_d;
      state_q     <= state_d;
      out_index_q <= out_index_d;
    end
  end

  assign out_valid     = (state_q == S_SEND);
  assign out_index     = out_index_q;
  assign covered_count = count_q;
  assign all_covered   = all_q;

endmodule

// File: tb/tb_toggle_cover_collector.sv
// Testbench for toggle_cover_collector: cycle table for the basic flow,
// scoreboard of expected cover indices for every accepted transfer, and
// hand-written sequences for stall, burst, clear and enable corner cases.
module tb_toggle_cover_collector;

  localparam int W  = 44;
  localparam int CI = 100;
  localparam int IW = 32;
`ifdef TOGGLE_COVER_FALL_EN
  localparam int NPTS = 2 * W;
  localparam bit FALL = 1'b1;
`else
  localparam int NPTS = W;
  localparam bit FALL = 1'b0;
`endif
  localparam int CW = $clog2(NPTS + 1);

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [W-1:0]  sig = '0;
  logic          enable = 1'b1;
  logic          clear = 1'b0;
  logic          out_ready = 1'b0;
  logic          out_valid;
  logic [IW-1:0] out_index;
  logic [CW-1:0] covered_count;
  logic          all_covered;

  always #5 clock = ~clock;

  toggle_cover_collector #(
    .WIDTH(W),
    .COVER_INDEX(CI),
    .IDX_W(IW)
  ) dut (
    .clock(clock),
    .reset(reset),
    .sig(sig),
    .enable(enable),
    .clear(clear),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_index(out_index),
    .covered_count(covered_count),
    .all_covered(all_covered)
  );

  int tests = 0;
  int fails = 0;

  // reference model state
  logic [NPTS-1:0] m_hit = '0;
  logic [W-1:0]    m_prev = '0;
  logic            m_primed = 1'b0;
  int              m_cnt = 0;
  logic [IW-1:0]   sbq[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Model of one rising edge, using the inputs currently driven
  task automatic model_edge();
    if (reset) begin
      m_hit = '0; m_prev = '0; m_primed = 1'b0; m_cnt = 0;
      sbq.delete();
    end else begin
      if (clear) begin
        m_hit = '0; m_cnt = 0;
        sbq.delete();
      end else if (m_primed && enable) begin
        for (int i = 0; i < W; i++)
          if (!m_prev[i] && sig[i] && !m_hit[i]) begin
            m_hit[i] = 1'b1; m_cnt++;
            sbq.push_back(IW'(CI + i));
          end
        if (FALL)
          for (int i = 0; i < W; i++)
            if (m_prev[i] && !sig[i] && !m_hit[(W + i) % NPTS]) begin
              m_hit[(W + i) % NPTS] = 1'b1; m_cnt++;
              sbq.push_back(IW'(CI + W + i));
            end
      end
      m_prev = sig; m_primed = 1'b1;
    end
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    #1;
  endtask

  // Accepted transfers are compared against the scoreboard mid-cycle
  always @(negedge clock) begin
    if (!reset && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sbq.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_index: got %0d expected none", out_index);
      end else begin
        chk("scoreboard_index", out_index, sbq.pop_front());
      end
    end
  end

  task automatic do_reset(input logic [W-1:0] s);
    reset = 1'b1; clear = 1'b0; enable = 1'b1; sig = s;
    step(); step();
    chk("reset_valid", out_valid, 0);
    chk("reset_index", out_index, 0);
    chk("reset_count", covered_count, 0);
    chk("reset_all", all_covered, 0);
    reset = 1'b0;
    step();
  endtask

  task automatic drain(input string name, input int bound);
    for (int n = 0; n < bound; n++) begin
      step();
      if (n >= 2 && sbq.size() == 0 && out_valid !== 1'b1) break;
    end
    chk({name, "_drained"}, sbq.size(), 0);
    chk({name, "_valid_low"}, out_valid, 0);
  endtask

  typedef struct {
    logic [W-1:0]  s;
    logic          rdy;
    logic          ev;
    logic [IW-1:0] ei;
    int            ec;
  } vec_t;

  vec_t tbl[6];

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int bad, seen, nv, first, last;
    logic [IW-1:0] held;

    tbl[0] = '{44'h0,  1'b1, 1'b0, 32'd0,   0};
    tbl[1] = '{44'h21, 1'b1, 1'b0, 32'd0,   2};
    tbl[2] = '{44'h21, 1'b1, 1'b1, 32'd100, 2};
    tbl[3] = '{44'h21, 1'b1, 1'b1, 32'd105, 2};
    tbl[4] = '{44'h21, 1'b1, 1'b0, 32'd0,   2};
    tbl[5] = '{44'h21, 1'b1, 1'b0, 32'd0,   2};

    // basic two-bit flow
    do_reset('0);
    for (int i = 0; i < 6; i++) begin
      sig = tbl[i].s; out_ready = tbl[i].rdy;
      step();
      chk($sformatf("vec%0d_valid", i), out_valid, tbl[i].ev);
      if (tbl[i].ev) chk($sformatf("vec%0d_index", i), out_index, tbl[i].ei);
      chk($sformatf("vec%0d_count", i), covered_count, tbl[i].ec);
    end
    chk("vec_all", all_covered, 0);
    chk("vec_sb_empty", sbq.size(), 0);

    // reset released with all ones: nothing counted
    do_reset({W{1'b1}});
    out_ready = 1'b1; bad = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (out_valid !== 1'b0) bad++;
    end
    chk("allones_no_valid", bad, 0);
    chk("allones_count", covered_count, 0);

    // bit 3 toggled under stall
    do_reset('0);
    out_ready = 1'b0; seen = 0; bad = 0; held = '0;
    for (int c = 0; c < 20; c++) begin
      sig = (c % 2 == 0) ? W'(8) : '0;
      step();
      if (seen != 0) begin
        if (out_valid !== 1'b1 || out_index !== held) bad++;
      end else if (out_valid === 1'b1) begin
        seen = 1; held = out_index;
      end
    end
    chk("stall_seen", seen, 1);
    chk("stall_held_index", held, CI + 3);
    chk("stall_stable", bad, 0);
    out_ready = 1'b1;
    drain("stall", 20);
    chk("stall_count", covered_count, FALL ? 2 : 1);

    // all bits rise at once
    do_reset('0);
    out_ready = 1'b1; sig = '1;
    nv = 0; first = -1; last = -1;
    for (int c = 0; c < 60; c++) begin
      step();
      if (out_valid === 1'b1) begin
        nv++; if (first < 0) first = c; last = c;
      end
    end
    chk("burst_valid_cycles", nv, W);
    chk("burst_contiguous", last - first + 1, W);
    chk("burst_count", covered_count, W);
    chk("burst_all", all_covered, FALL ? 0 : 1);
    chk("burst_sb_empty", sbq.size(), 0);
    if (FALL) begin
      sig = '0;
      drain("fall_burst", 60);
      chk("fall_burst_count", covered_count, NPTS);
      chk("fall_burst_all", all_covered, 1);
    end

    // clear while sending with three more pending
    do_reset('0);
    out_ready = 1'b0; sig = W'(32'h1E);
    step(); step();
    chk("clr_pre_valid", out_valid, 1);
    chk("clr_pre_index", out_index, CI + 1);
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("clr_valid", out_valid, 0);
    chk("clr_count", covered_count, 0);
    chk("clr_all", all_covered, 0);
    step();
    chk("clr_stays_idle", out_valid, 0);
    out_ready = 1'b1; sig = '0;
    drain("clr_fall", 40);
    sig = W'(32'h1E);
    drain("clr_rise", 40);
    chk("clr_recount", covered_count, FALL ? 8 : 4);

    // toggles while disabled are tracked but not counted
    do_reset('0);
    enable = 1'b0; out_ready = 1'b1;
    sig = W'(32'hF0);  step();
    sig = '0;          step();
    sig = W'(32'hF00); step();
    enable = 1'b1; bad = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (out_valid !== 1'b0) bad++;
    end
    chk("en_no_valid", bad, 0);
    chk("en_count", covered_count, 0);
    sig = W'(32'hF01);
    drain("en_after", 20);
    chk("en_after_count", covered_count, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
